bp_table_ctrl: RTL and testbench
================================

// Module: bp_table_ctrl
// PURPOSE
//  Owns and sequences a pattern-history table of 2-bit saturating branch counters.
//  The table is shared between the fetch-side lookup port and the resolve-side update port.
//  The table allows one operation per cycle: a lookup read, or an update read-modify-write.
//  Updates are buffered in a small FIFO; the block arbitrates between lookups and queued updates.
//  After reset or flush, an init sweep writes every entry before traffic is accepted.
// PARAMETERS
//  IDX_W      6      table index width; table holds 2**IDX_W counters
//  FIFO_DEPTH 4      update queue depth; power of 2, >= 2
//  INIT_VAL   2'b11  counter value written by the init sweep (strongly taken)
// PORTS
//  clk          in   1      clock, all state on posedge
//  rst_n        in   1      asynchronous active-low reset
//  flush        in   1      sync: drop queued updates, re-run init sweep
//  lookup_valid in   1      lookup request
//  lookup_ready out  1      lookup accepted when valid&&ready
//  lookup_idx   in   IDX_W  entry to read
//  pred_valid   out  1      one-cycle pulse, prediction available
//  pred_taken   out  1      predicted direction (counter >= 2'b10)
//  upd_valid    in   1      resolved-branch update request
//  upd_ready    out  1      update enqueued when valid&&ready
//  upd_idx      in   IDX_W  entry to update
//  upd_taken    in   1      resolved direction
//  busy         out  1      init sweep in progress
// BEHAVIOUR
//  Reset (async, rst_n=0): state=INIT, sweep ptr=0, FIFO empty.
//   Output reset values: pred_valid=0, pred_taken=0, lookup_ready=0, upd_ready=0, busy=1.
//  FSM INIT: writes INIT_VAL to entry ptr and increments ptr, one entry per cycle.
//   Takes exactly 2**IDX_W cycles; after the last entry it goes to RUN.
//   busy=1; lookup_ready=0; upd_ready=0.
//  FSM RUN: busy=0. flush in RUN or INIT -> INIT, ptr=0, FIFO emptied, queued updates discarded.
//   flush has priority over every other event in the same cycle.
//  lookup_ready = RUN && !fifo_full (combinational from state and FIFO count).
//  upd_ready = RUN && !fifo_full. No enqueue while full, even in a cycle that drains.
//  Arbitration in RUN, one table op per cycle:
//   1. FIFO full -> drain the head update; lookups are blocked.
//   2. Accepted lookup -> read the table; no drain this cycle.
//   3. No accepted lookup and FIFO non-empty -> drain the head update.
//  Enqueue and drain may occur in the same cycle; the count is unchanged.
//  Lookup latency: accepted in cycle N -> pred_valid=1 in N+1 with pred_taken = (ctr[idx] >= 2).
//   pred_taken holds its last value while pred_valid=0.
//  Drain: ctr <= taken ? (ctr==3 ? 3 : ctr+1) : (ctr==0 ? 0 : ctr-1); saturates, never wraps.
//  Ordering: a drain written in cycle N is visible to a lookup accepted in N+1 or later.
//   No forwarding from the FIFO: a lookup of an entry with a queued update returns the table value.
//  Updates to the same index drain in arrival order; each one is applied individually.
// TESTING (IDX_W=3, FIFO_DEPTH=4)
//  T1 Release rst_n: busy=1 for 8 cycles, then lookup_ready=1.
//     Lookup idx5 -> next cycle pred_valid=1, pred_taken=1.
//  T2 Two not-taken updates to idx2, no lookups: ctr 11->10->01.
//     Lookup idx2 -> pred_taken=0. Two more not-taken -> ctr stays 00.
//     One taken -> 01, pred_taken still 0.
//  T3 Lookups every cycle plus 4 update pushes: FIFO fills, upd_ready=0 and lookup_ready=0.
//     Next cycle one update drains, both readies return to 1.
//  T4 Three taken updates to idx0 from 11: ctr stays 11, pred_taken=1 throughout.
//  T5 Flush with 2 updates queued: both are dropped, busy=1 for 8 cycles.
//     Every entry reads back pred_taken=1 (INIT_VAL).
//  T6 rst_n low mid-sweep (ptr=4): outputs go to reset values immediately.
//     After release, the full 8-cycle sweep restarts from ptr=0.

Source files
------------

// File: rtl/bp_table_ctrl.sv
// bp_table_ctrl: pattern-history table of 2-bit saturating branch counters.
// The table does one operation per cycle. That operation is a lookup read or a
// read-modify-write that drains one queued update. Resolved-branch updates wait in
// a small FIFO. After reset or flush, an init sweep writes INIT_VAL to every entry.
// Traffic is not accepted until the sweep completes.
//
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   flush                       drop queued updates, restart the init sweep
//   lookup_valid/ready/idx      fetch-side read request
//   pred_valid, pred_taken      prediction, one cycle after an accepted lookup
//   upd_valid/ready/idx/taken   resolve-side update request (enqueued)
//   busy                        init sweep in progress
module bp_table_ctrl #(
  parameter int         IDX_W      = 6,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_VAL   = 2'b11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             lookup_valid,
  output logic             lookup_ready,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             upd_valid,
  output logic             upd_ready,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             busy
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int FP_W    = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = FP_W + 1;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t state, state_nxt;
  logic [IDX_W-1:0] ptr;

  logic [1:0] tbl [ENTRIES];

  // update queue: circular buffer, pointers wrap naturally (depth is 2**n)
  logic [IDX_W-1:0] q_idx [FIFO_DEPTH];
  logic             q_tkn [FIFO_DEPTH];
  logic [FP_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  logic run, fifo_full, fifo_empty;
  logic lk_fire, enq, drain;
  logic [IDX_W-1:0] head_idx;
  logic             head_tkn;
  logic [1:0]       head_ctr, ctr_nxt;

  assign run        = (state == S_RUN);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  assign lookup_ready = run && !fifo_full;
  assign upd_ready    = run && !fifo_full;
  assign busy         = (state == S_INIT);

  // flush wins over everything: nothing is accepted or drained in that cycle
  assign lk_fire = lookup_valid && lookup_ready && !flush;
  assign enq     = upd_valid && upd_ready && !flush;
  // a full queue steals the table port; otherwise lookups take priority
  assign drain   = run && !flush && (fifo_full || (!lk_fire && !fifo_empty));

  assign head_idx = q_idx[rd_ptr];
  assign head_tkn = q_tkn[rd_ptr];
  assign head_ctr = tbl[head_idx];

  always_comb begin
    ctr_nxt = head_ctr;
    if (head_tkn) begin
      if (head_ctr != 2'b11) ctr_nxt = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) ctr_nxt = head_ctr - 2'b01;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush)                                       state_nxt = S_INIT;
    else if (state == S_INIT && ptr == {IDX_W{1'b1}}) state_nxt = S_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (flush)                 ptr <= '0;
      else if (state == S_INIT)  ptr <= ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_idx[wr_ptr] <= upd_idx;
      q_tkn[wr_ptr] <= upd_taken;
    end
  end

  // The table has no reset. The sweep defines every entry before the first read.
  always_ff @(posedge clk) begin
    if (state == S_INIT) tbl[ptr]      <= INIT_VAL;
    else if (drain)      tbl[head_idx] <= ctr_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= lk_fire;
      if (lk_fire) pred_taken <= tbl[lookup_idx][1];
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Self-checking bench for bp_table_ctrl (IDX_W=3, FIFO_DEPTH=4). It runs directed
// scenarios and then a randomized phase. A reference model tracks the counter array,
// the update queue and the run/sweep status. The bench compares that model against
// the DUT every cycle.
module tb_bp_table_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       lookup_valid = 1'b0;
  logic       lookup_ready;
  logic [2:0] lookup_idx = '0;
  logic       pred_valid, pred_taken;
  logic       upd_valid = 1'b0;
  logic       upd_ready;
  logic [2:0] upd_idx = '0;
  logic       upd_taken = 1'b0;
  logic       busy;

  bp_table_ctrl #(.IDX_W(3), .FIFO_DEPTH(4), .INIT_VAL(2'b11)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready), .lookup_idx(lookup_idx),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_idx(upd_idx), .upd_taken(upd_taken),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  typedef struct { int idx; bit tkn; } upd_t;
  bit   m_run;
  int   m_init_left;
  int   m_tbl [8];
  upd_t m_q [$];
  bit   m_pv, m_pt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_init_left = 8; m_q.delete(); m_pv = 0; m_pt = 0;
    foreach (m_tbl[i]) m_tbl[i] = 3;
  endtask

  task automatic model_step(input bit lv, input int li, input bit uv, input int ui,
                            input bit ut, input bit fl);
    bit full, lk, en;
    upd_t u;
    if (fl) begin
      m_run = 0; m_init_left = 8; m_q.delete(); m_pv = 0;
      foreach (m_tbl[i]) m_tbl[i] = 3;
    end else if (!m_run) begin
      m_pv = 0;
      m_init_left--;
      if (m_init_left == 0) m_run = 1;
    end else begin
      full = (m_q.size() == 4);
      lk   = lv && !full;
      en   = uv && !full;
      m_pv = lk;
      if (lk) m_pt = (m_tbl[li] >= 2);
      if (full || (!lk && m_q.size() > 0)) begin
        u = m_q.pop_front();
        if (u.tkn) m_tbl[u.idx] = (m_tbl[u.idx] == 3) ? 3 : m_tbl[u.idx] + 1;
        else       m_tbl[u.idx] = (m_tbl[u.idx] == 0) ? 0 : m_tbl[u.idx] - 1;
      end
      if (en) begin
        u.idx = ui; u.tkn = ut;
        m_q.push_back(u);
      end
    end
  endtask

  // One clock cycle. Inputs are driven here, readies and busy are checked at the
  // negedge, and the prediction outputs are checked 1ns after the posedge.
  task automatic cyc(input bit lv, input int li, input bit uv, input int ui,
                     input bit ut, input bit fl);
    bit exp_rdy;
    lookup_valid = lv; lookup_idx = li[2:0];
    upd_valid = uv; upd_idx = ui[2:0]; upd_taken = ut;
    flush = fl;
    @(negedge clk);
    exp_rdy = m_run && (m_q.size() < 4);
    chk("busy", busy, !m_run);
    chk("lookup_ready", lookup_ready, exp_rdy);
    chk("upd_ready", upd_ready, exp_rdy);
    model_step(lv, li, uv, ui, ut, fl);
    @(posedge clk); #1;
    chk("pred_valid", pred_valid, m_pv);
    chk("pred_taken", pred_taken, m_pt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    lookup_valid = 0; upd_valid = 0; flush = 0;
    rst_n = 1'b0;
    #2;
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_pred_taken", pred_taken, 0);
    chk("rst_lookup_ready", lookup_ready, 0);
    chk("rst_upd_ready", upd_ready, 0);
    chk("rst_busy", busy, 1);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // T1: reset, an 8-cycle sweep, then a lookup returns INIT_VAL (taken)
    #3;
    do_reset();
    idle(8);
    chk("t1_ready", lookup_ready, 1);
    chk("t1_busy", busy, 0);
    cyc(1, 5, 0, 0, 0, 0);
    chk("t1_pred_valid", pred_valid, 1);
    chk("t1_pred_taken", pred_taken, 1);

    // T2: entry 2 decrements 11->10->01, saturates at 00, then increments to 01
    cyc(0, 0, 1, 2, 0, 0);
    cyc(0, 0, 1, 2, 0, 0);
    idle(2);
    cyc(1, 2, 0, 0, 0, 0);
    chk("t2_nt_after2", pred_taken, 0);
    cyc(0, 0, 1, 2, 0, 0);
    cyc(0, 0, 1, 2, 0, 0);
    idle(2);
    cyc(0, 0, 1, 2, 1, 0);
    idle(1);
    cyc(1, 2, 0, 0, 0, 0);
    chk("t2_pv", pred_valid, 1);
    chk("t2_taken_once", pred_taken, 0);

    // T3: lookups every cycle block draining until the queue fills
    for (int i = 0; i < 4; i++) cyc(1, i, 1, 4 + i, i[0], 0);
    chk("t3_lk_blocked", lookup_ready, 0);
    chk("t3_upd_blocked", upd_ready, 0);
    cyc(1, 1, 1, 1, 1, 0);
    chk("t3_lk_back", lookup_ready, 1);
    chk("t3_upd_back", upd_ready, 1);
    idle(4);

    // T4: taken updates on a saturated entry leave it at 11
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk("t4_taken", pred_taken, 1);
    end
    idle(2);

    // T5: flush drops two queued not-taken updates and re-runs the sweep
    cyc(1, 3, 1, 6, 0, 0);
    cyc(1, 3, 1, 6, 0, 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("t5_busy", busy, 1);
    idle(8);
    for (int i = 0; i < 8; i++) begin
      cyc(1, i, 0, 0, 0, 0);
      chk("t5_init_val", pred_taken, 1);
    end

    // T6: reset in the middle of a sweep, then the full sweep restarts
    do_reset();
    idle(4);
    do_reset();
    idle(8);
    chk("t6_ready", lookup_ready, 1);

    // randomized traffic: small index range for collisions, occasional flush
    for (int n = 0; n < 800; n++) begin
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 7),
          $urandom_range(0, 99) < 60, $urandom_range(0, 3),
          $urandom_range(0, 1), $urandom_range(0, 99) == 0);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
